vga_pattern_sm: RTL and testbench

Parametrised VGA display state machine with its own sync timing generator and a pixel pipeline that renders one of four test/animation patterns. It is gated by the top-level master state machine: it shows patterns only while the master is in its display state. It drives the board's VGA connector directly. Timing, colour depth, pixel-clock division and frame-counter width are parameters.

---
 rtl/vga_pattern_sm.sv | 179 +++++++++++++++++
 tb/tb_vga_pattern_sm.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_pattern_sm.sv
// VGA display state machine: sync timing generator, pattern pipeline and
// IDLE/ARMED/ACTIVE gating driven by the master state machine.
module vga_pattern_sm #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP = 33,
  parameter int CLK_DIV = 4,
  parameter int COLOUR_W = 12,
  parameter int FRAME_CNT_W = 16,
  parameter logic [1:0] ENABLE_STATE = 2'b10
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [1:0]          MASTER_STATE,
  input  logic [1:0]          MODE,
  output logic [COLOUR_W-1:0] COLOUR_OUT,
  output logic                HS,
  output logic                VS,
  output logic                FRAME_START,
  output logic [1:0]          DISP_STATE
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HCNT_W = $clog2(H_TOTAL);
  localparam int VCNT_W = $clog2(V_TOTAL);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int C_W = COLOUR_W / 3;

  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [HCNT_W-1:0] H_LAST = HCNT_W'(H_TOTAL - 1);
  localparam logic [HCNT_W-1:0] H_VIS = HCNT_W'(H_ACTIVE);
  localparam logic [HCNT_W-1:0] HS_START = HCNT_W'(H_ACTIVE + H_FP);
  localparam logic [HCNT_W-1:0] HS_END = HCNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HCNT_W-1:0] H_MID = HCNT_W'(H_ACTIVE / 2);
  localparam logic [VCNT_W-1:0] V_LAST = VCNT_W'(V_TOTAL - 1);
  localparam logic [VCNT_W-1:0] V_VIS = VCNT_W'(V_ACTIVE);
  localparam logic [VCNT_W-1:0] VS_START = VCNT_W'(V_ACTIVE + V_FP);
  localparam logic [VCNT_W-1:0] VS_END = VCNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VCNT_W-1:0] V_MID = VCNT_W'(V_ACTIVE / 2);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ARMED  = 2'b01,
    ST_ACTIVE = 2'b10
  } state_t;

  state_t                  state_reg, state_next;
  logic [DIV_W-1:0]        div_reg;
  logic [HCNT_W-1:0]       h_reg;
  logic [VCNT_W-1:0]       v_reg;
  logic [FRAME_CNT_W-1:0]  frame_cnt_reg;
  logic [1:0]              mode_q_reg;
  logic [COLOUR_W-1:0]     colour_reg;
  logic                    hs_reg, vs_reg, frame_start_reg;

  logic                    tick, frame_tick, in_active;
  logic [1:0]              mode_eff;
  logic [FRAME_CNT_W-1:0]  frame_eff;
  logic [6:0]              bar_ge;
  logic [2:0]              bar_idx;
  logic [COLOUR_W-1:0]     bar_colour, pixel_colour;
  logic [HCNT_W-1:0]       dx;
  logic [VCNT_W-1:0]       dy;
  logic [31:0]             diamond_sum;

  assign tick = (div_reg == '0);
  assign frame_tick = tick && (h_reg == '0) && (v_reg == '0);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      div_reg       <= '0;
      h_reg         <= '0;
      v_reg         <= '0;
      frame_cnt_reg <= '0;
      mode_q_reg    <= '0;
    end else begin
      div_reg <= (div_reg == DIV_LAST) ? '0 : div_reg + DIV_W'(1);
      if (tick) begin
        if (h_reg == H_LAST) begin
          h_reg <= '0;
          v_reg <= (v_reg == V_LAST) ? '0 : v_reg + VCNT_W'(1);
        end else begin
          h_reg <= h_reg + HCNT_W'(1);
        end
      end
      if (frame_tick) begin
        frame_cnt_reg <= frame_cnt_reg + FRAME_CNT_W'(1);
        mode_q_reg    <= MODE;
      end
    end
  end

  // The first pixel of a frame already sees the new mode and frame count,
  // so every pixel of a frame is rendered with the same values.
  assign mode_eff = frame_tick ? MODE : mode_q_reg;
  assign frame_eff = frame_tick ? frame_cnt_reg + FRAME_CNT_W'(1) : frame_cnt_reg;

  always_ff @(posedge CLK) begin
    if (RESET) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (MASTER_STATE != ENABLE_STATE) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE:   state_next = ST_ARMED;
        ST_ARMED:  if (frame_tick) state_next = ST_ACTIVE;
        ST_ACTIVE: state_next = ST_ACTIVE;
        default:   state_next = ST_IDLE;
      endcase
    end
  end

  // Bar index is a thermometer of x against ceil(i*H_ACTIVE/8).
  genvar gi;
  generate
    for (gi = 1; gi < 8; gi++) begin : g_bar_edge
      localparam logic [HCNT_W-1:0] EDGE = HCNT_W'((gi * H_ACTIVE + 7) / 8);
      assign bar_ge[gi-1] = (h_reg >= EDGE);
    end
  endgenerate

  always_comb begin
    bar_idx = '0;
    for (int i = 0; i < 7; i++) bar_idx = bar_idx + {2'b00, bar_ge[i]};
  end

  assign bar_colour = {{C_W{~bar_idx[1]}}, {C_W{~bar_idx[2]}}, {C_W{~bar_idx[0]}}};
  assign dx = (h_reg >= H_MID) ? h_reg - H_MID : H_MID - h_reg;
  assign dy = (v_reg >= V_MID) ? v_reg - V_MID : V_MID - v_reg;
  assign diamond_sum = 32'(frame_eff[FRAME_CNT_W-1 -: 8]) + 32'(dx) + 32'(dy);
  assign in_active = (h_reg < H_VIS) && (v_reg < V_VIS);

  always_comb begin
    pixel_colour = '0;
    if (in_active) begin
      case (mode_eff)
        2'd1:    pixel_colour = bar_colour;
        2'd2:    pixel_colour = {COLOUR_W{h_reg[5] ^ v_reg[5]}};
        2'd3:    pixel_colour = COLOUR_W'(diamond_sum);
        default: pixel_colour = '0;
      endcase
    end
  end

  // Colour blanks on the very CLK the display leaves ACTIVE, not at the next tick.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      colour_reg      <= '0;
      hs_reg          <= 1'b1;
      vs_reg          <= 1'b1;
      frame_start_reg <= 1'b0;
    end else begin
      frame_start_reg <= frame_tick;
      if (state_next != ST_ACTIVE) colour_reg <= '0;
      else if (tick)               colour_reg <= pixel_colour;
      if (tick) begin
        hs_reg <= !((h_reg >= HS_START) && (h_reg < HS_END));
        vs_reg <= !((v_reg >= VS_START) && (v_reg < VS_END));
      end
    end
  end

  assign COLOUR_OUT  = colour_reg;
  assign HS          = hs_reg;
  assign VS          = vs_reg;
  assign FRAME_START = frame_start_reg;
  assign DISP_STATE  = state_reg;

endmodule

// File: tb/tb_vga_pattern_sm.sv
// Bench for vga_pattern_sm with a reduced display geometry; expected outputs
// come from pixel-index arithmetic on the cycle count since reset.
module tb_vga_pattern_sm;
  localparam int HA = 64, HFP = 2, HSW = 4, HBP = 2;
  localparam int VA = 36, VFP = 1, VSW = 2, VBP = 1;
  localparam int DIV = 2, CW = 12, FW = 8;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VT = VA + VFP + VSW + VBP;
  localparam int FT = HT * VT;
  localparam int FRAME_CLKS = FT * DIV;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic [1:0]    MASTER_STATE = 2'b00;
  logic [1:0]    MODE = 2'b00;
  logic [CW-1:0] COLOUR_OUT;
  logic          HS, VS, FRAME_START;
  logic [1:0]    DISP_STATE;

  vga_pattern_sm #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .CLK_DIV(DIV), .COLOUR_W(CW), .FRAME_CNT_W(FW), .ENABLE_STATE(2'b10)
  ) dut (
    .CLK(CLK), .RESET(RESET), .MASTER_STATE(MASTER_STATE), .MODE(MODE),
    .COLOUR_OUT(COLOUR_OUT), .HS(HS), .VS(VS),
    .FRAME_START(FRAME_START), .DISP_STATE(DISP_STATE)
  );

  always #5 CLK = ~CLK;

  int checks = 0, errors = 0;
  int mc = 0, total_cyc = 0, last_fs = -1;
  int m_st = 0, m_mode_q = 0, m_col = 0, m_hs = 1, m_vs = 1, m_fs = 0;
  int m_tick = 0, m_px = 0, m_py = 0, m_frames = 0;
  logic [11:0] bar_tab [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                               12'hF0F, 12'hF00, 12'h00F, 12'h000};

  function automatic int iabs(int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int pattern(int x, int y, int mode, int frames);
    int f;
    if (x >= HA || y >= VA) return 0;
    f = (frames % (1 << FW)) >> (FW - 8);
    case (mode)
      1: return int'(bar_tab[x * 8 / HA]);
      2: return (((x / 32) + (y / 32)) % 2 == 1) ? 'hFFF : 0;
      3: return (f + iabs(x - HA / 2) + iabs(y - VA / 2)) % (1 << CW);
      default: return 0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit next_is_fs();
    return !RESET && (mc % DIV == 0) && ((mc / DIV) % FT == 0);
  endfunction

  // One CLK: predict the outputs after the coming edge, then compare all of them.
  task automatic step();
    int tick, k, x, y, fs, mode_eff;
    if (RESET) begin
      mc = 0; m_st = 0; m_mode_q = 0; m_col = 0; m_hs = 1; m_vs = 1;
      m_fs = 0; m_tick = 0; last_fs = -1;
    end else begin
      tick = (mc % DIV == 0);
      k = mc / DIV;
      x = k % HT;
      y = (k / HT) % VT;
      fs = tick && x == 0 && y == 0;
      if (MASTER_STATE != 2'b10) m_st = 0;
      else if (m_st == 0) m_st = 1;
      else if (m_st == 1 && fs) m_st = 2;
      mode_eff = fs ? int'(MODE) : m_mode_q;
      if (fs) m_mode_q = int'(MODE);
      m_frames = k / FT + 1;
      if (m_st != 2) m_col = 0;
      else if (tick) m_col = pattern(x, y, mode_eff, m_frames);
      if (tick) begin
        m_hs = (x >= HA + HFP && x < HA + HFP + HSW) ? 0 : 1;
        m_vs = (y >= VA + VFP && y < VA + VFP + VSW) ? 0 : 1;
      end
      m_fs = fs; m_tick = tick; m_px = x; m_py = y;
      mc++;
    end
    @(posedge CLK);
    #1;
    total_cyc++;
    check("colour", COLOUR_OUT, m_col);
    check("hs", HS, m_hs);
    check("vs", VS, m_vs);
    check("frame_start", FRAME_START, m_fs);
    check("disp_state", DISP_STATE, m_st);
    if (FRAME_START === 1'b1) begin
      if (last_fs >= 0) check("fs_interval", total_cyc - last_fs, FRAME_CLKS);
      last_fs = total_cyc;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_to_pixel(input int x, input int y, input string tag);
    bit found = 0;
    for (int i = 0; i < 2 * FRAME_CLKS && !found; i++) begin
      step();
      found = m_tick != 0 && m_px == x && m_py == y;
    end
    check({tag, "_reached"}, found, 1);
  endtask

  task automatic run_to_fs_edge(input string tag);
    bit found = next_is_fs();
    for (int i = 0; i < 2 * FRAME_CLKS && !found; i++) begin
      step();
      found = next_is_fs();
    end
    check({tag, "_reached"}, found, 1);
  endtask

  task automatic wait_fs_obs(input string tag);
    bit found = 0;
    for (int i = 0; i < 2 * FRAME_CLKS && !found; i++) begin
      step();
      found = (FRAME_START === 1'b1);
    end
    check({tag, "_reached"}, found, 1);
  endtask

  task automatic run_to_hs_low(input string tag);
    bit found = 0;
    for (int i = 0; i < 4 * HT * DIV && !found; i++) begin
      step();
      found = (m_hs == 0);
    end
    check({tag, "_reached"}, found, 1);
  endtask

  initial begin
    RESET = 1'b1;
    run(5);
    check("rst_colour", COLOUR_OUT, 12'h000);
    check("rst_hs", HS, 1);
    check("rst_vs", VS, 1);
    check("rst_state", DISP_STATE, 2'b00);
    RESET = 1'b0;
    MODE = 2'd1;
    run(1000);

    MASTER_STATE = 2'b10;
    step();
    check("arm_state", DISP_STATE, 2'b01);
    wait_fs_obs("arm_fs");
    check("arm_active", DISP_STATE, 2'b10);

    run_to_pixel(0, 1, "bar0");   check("bar_x0", COLOUR_OUT, 12'hFFF);
    run_to_pixel(8, 1, "bar1");   check("bar_x8", COLOUR_OUT, 12'hFF0);
    run_to_pixel(36, 1, "bar4");  check("bar_x36", COLOUR_OUT, 12'hF0F);
    run_to_pixel(56, 1, "bar7");  check("bar_x56", COLOUR_OUT, 12'h000);
    run_to_pixel(64, 1, "bar_o"); check("bar_x64", COLOUR_OUT, 12'h000);

    MODE = 2'd2;
    run_to_pixel(8, 3, "latch_hold");  check("latch_hold", COLOUR_OUT, 12'hFF0);
    run_to_pixel(0, 0, "chk00");       check("chk_0_0", COLOUR_OUT, 12'h000);
    run_to_pixel(32, 0, "chk320");     check("chk_32_0", COLOUR_OUT, 12'hFFF);
    run_to_pixel(32, 32, "chk3232");   check("chk_32_32", COLOUR_OUT, 12'h000);
    run_to_pixel(0, 32, "chk032");     check("chk_0_32", COLOUR_OUT, 12'hFFF);

    MODE = 2'd3;
    run_to_pixel(0, 0, "dia00");
    check("dia_0_0", COLOUR_OUT, (m_frames + HA / 2 + VA / 2) % 4096);
    run_to_pixel(32, 18, "diactr");
    check("dia_ctr", COLOUR_OUT, m_frames % 4096);
    run_to_pixel(63, 35, "diaend");
    check("dia_63_35", COLOUR_OUT, (m_frames + 31 + 17) % 4096);

    run_to_pixel(10, 10, "drop_pos");
    step();
    MASTER_STATE = 2'b00;
    step();
    check("drop_state", DISP_STATE, 2'b00);
    check("drop_colour", COLOUR_OUT, 12'h000);

    run_to_fs_edge("sim_entry");
    MASTER_STATE = 2'b10;
    step();
    check("sim_entry_state", DISP_STATE, 2'b01);
    check("sim_entry_fs", FRAME_START, 1);
    wait_fs_obs("sim_next");
    check("sim_next_state", DISP_STATE, 2'b10);
    run_to_fs_edge("sim_leave");
    MASTER_STATE = 2'b00;
    step();
    check("sim_leave_state", DISP_STATE, 2'b00);
    check("sim_leave_fs", FRAME_START, 1);

    MASTER_STATE = 2'b10;
    run_to_hs_low("mid_rst");
    RESET = 1'b1;
    step();
    check("mid_rst_hs", HS, 1);
    check("mid_rst_vs", VS, 1);
    RESET = 1'b0;
    run(3000);

    for (int i = 0; i < 15000; i++) begin
      if ($urandom_range(0, 2999) == 0)
        MASTER_STATE = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b10;
      if ($urandom_range(0, 999) == 0)
        MODE = 2'($urandom_range(0, 3));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
